// File: rtl/fml_pkg.sv
// fml_pkg: burst geometry and FSM state encoding shared by the FML block-RAM slave.
package fml_pkg;
   localparam int FML_BURST_LEN = 4;
   localparam int FML_DW        = 32;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, WAIT = ST_WAIT, BURST = ST_BURST} fml_state_t;
endpackage

// File: rtl/fml_bram_ram.sv
// fml_bram_ram: single-port synchronous RAM with per-byte write enables; contents never reset.
module fml_bram_ram
   import fml_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [AW-1:0]     addr,
   input  logic [FML_DW-1:0] di,
   output logic [FML_DW-1:0] q
);
   logic [FML_DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      q <= mem[addr];
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= di[8*i +: 8];
   end
endmodule

// File: rtl/fml_bram.sv
// fml_bram: FML burst slave on block RAM with programmable ack latency.
// Define FML_BRAM_SEL_EN to honour fml_sel byte enables on write beats.
module fml_bram
   import fml_pkg::*;
#(
   parameter int ADR_WIDTH  = 26,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [ADR_WIDTH-1:0] fml_adr,
   input  logic                 fml_stb,
   input  logic                 fml_we,
   input  logic [3:0]           fml_sel,
   input  logic [FML_DW-1:0]    fml_di,
   output logic                 fml_ack,
   output logic [FML_DW-1:0]    fml_do
);
   fml_state_t              state;
   logic [DEPTH_LOG2-3:0]   base_r;
   logic                    we_r;
   logic [3:0]              cnt;
   logic [1:0]              beat;
   logic [DEPTH_LOG2-1:0]   ram_addr;
   logic [3:0]              ram_be;
   logic                    ram_we;
   logic [FML_DW-1:0]       ram_q;
   logic                    unused_bits;

   assign unused_bits = ^{fml_adr, fml_sel};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         base_r  <= '0;
         we_r    <= 1'b0;
         cnt     <= '0;
         beat    <= '0;
         fml_ack <= 1'b0;
      end else begin
         fml_ack <= 1'b0;
         case (state)
            IDLE: if (fml_stb) begin
               base_r  <= fml_adr[DEPTH_LOG2+1:4];
               we_r    <= fml_we;
               cnt     <= 4'(LATENCY - 1);
               beat    <= '0;
               state   <= (LATENCY == 1) ? BURST : WAIT;
               fml_ack <= (LATENCY == 1);
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state   <= BURST;
                  fml_ack <= 1'b1;
               end
            end
            BURST: begin
               beat <= beat + 2'd1;
               if (beat == 2'(FML_BURST_LEN - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reads look one beat ahead so the synchronous RAM output lines up with each burst cycle.
   always_comb begin
      ram_addr = {(state == IDLE) ? fml_adr[DEPTH_LOG2+1:4] : base_r,
                  (state == BURST) ? (we_r ? beat : beat + 2'd1) : 2'd0};
      ram_we   = (state == BURST) && we_r;
`ifdef FML_BRAM_SEL_EN
      ram_be   = fml_sel;
`else
      ram_be   = 4'hF;
`endif
      fml_do   = (state == BURST && !we_r) ? ram_q : '0;
   end

   fml_bram_ram #(.AW(DEPTH_LOG2)) u_ram (
      .clk  (sys_clk),
      .we   (ram_we),
      .be   (ram_be),
      .addr (ram_addr),
      .di   (fml_di),
      .q    (ram_q)
   );
endmodule

// File: tb/tb_fml_bram.sv
// tb_fml_bram: directed checks of latency, burst data, byte enables, reset and address wrap.
module tb_fml_bram;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb0 = 1'b0, stb1 = 1'b0;
   logic [25:0] adr = '0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] di = '0;
   logic        ack0, ack1;
   logic [31:0] do0, do1;
   int          checks = 0;
   int          errors = 0;
   logic        ack_log [32];
   logic [31:0] do_log [32];
   logic [31:0] pre [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
   logic [31:0] wr  [4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
   logic [31:0] old [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
   logic [31:0] nw  [4] = '{32'h50505050, 32'h51515151, 32'h52525252, 32'h53535353};
   logic [31:0] ones[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] sw  [4] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] wrp [4] = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};

   always #5 clk = ~clk;

   fml_bram #(.ADR_WIDTH(26), .DEPTH_LOG2(10), .LATENCY(3)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .fml_adr(adr), .fml_stb(stb0), .fml_we(we),
      .fml_sel(sel), .fml_di(di), .fml_ack(ack0), .fml_do(do0));

   fml_bram #(.ADR_WIDTH(26), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .fml_adr(adr), .fml_stb(stb1), .fml_we(we),
      .fml_sel(sel), .fml_di(di), .fml_ack(ack1), .fml_do(do1));

   task automatic burst(input int u, input logic w, input logic [25:0] a, input logic [31:0] wd [4],
                        input logic [3:0] s, input int n, input int rst_at);
      int l = u ? 1 : 3;
      bit got = 0;
      adr = a; we = w; sel = s;
      for (int c = 0; c < n; c++) begin
         di = 32'h0;
         if (c >= l && c < l + 4) di = wd[c-l];
         if (c == rst_at) rst_n = 1'b0;
         if (u != 0) stb1 = !got; else stb0 = !got;
         #1;
         ack_log[c] = u ? ack1 : ack0;
         do_log[c]  = u ? do1 : do0;
         if (ack_log[c]) begin got = 1; stb0 = 1'b0; stb1 = 1'b0; end
         @(posedge clk); #1;
      end
      stb0 = 1'b0; stb1 = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", ack0); end
      checks++; if (do0 !== 32'h0) begin errors++; $display("FAIL reset_do0 got %h want 0", do0); end
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got %b want 0", ack1); end
      checks++; if (do1 !== 32'h0) begin errors++; $display("FAIL reset_do1 got %h want 0", do1); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read;
      logic [31:0] e;
      burst(0, 1'b1, 26'h0, pre, 4'hF, 8, -1);
      burst(0, 1'b0, 26'h0, pre, 4'hF, 8, -1);
      for (int c = 0; c < 8; c++) begin
         e = (c >= 3 && c <= 6) ? pre[c-3] : 32'h0;
         checks++; if (ack_log[c] !== (c == 3)) begin errors++; $display("FAIL read_ack c%0d got %b want %b", c, ack_log[c], c == 3); end
         checks++; if (do_log[c] !== e) begin errors++; $display("FAIL read_do c%0d got %h want %h", c, do_log[c], e); end
      end
   endtask

   task automatic test_write_read;
      burst(0, 1'b1, 26'h40, wr, 4'hF, 8, -1);
      burst(0, 1'b0, 26'h40, wr, 4'hF, 8, -1);
      for (int b = 0; b < 4; b++) begin
         checks++; if (do_log[3+b] !== wr[b]) begin errors++; $display("FAIL wr_rd beat%0d got %h want %h", b, do_log[3+b], wr[b]); end
      end
   endtask

   task automatic test_sel;
      logic [31:0] e;
`ifdef FML_BRAM_SEL_EN
      e = 32'hFF00FF00;
`else
      e = 32'h00000000;
`endif
      burst(0, 1'b1, 26'h80, ones, 4'hF, 8, -1);
      burst(0, 1'b1, 26'h80, sw, 4'b0101, 8, -1);
      burst(0, 1'b0, 26'h80, ones, 4'hF, 8, -1);
      checks++; if (do_log[3] !== e) begin errors++; $display("FAIL sel_beat0 got %h want %h", do_log[3], e); end
      checks++; if (do_log[4] !== 32'hFFFFFFFF) begin errors++; $display("FAIL sel_beat1 got %h want ffffffff", do_log[4]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e;
      logic        ea;
      adr = 26'h0; we = 1'b0; stb0 = 1'b1;
      for (int c = 0; c < 18; c++) begin
         #1;
         ea = (c == 3 || c == 10);
         e = 32'h0;
         if (c >= 3 && c <= 6) e = pre[c-3];
         if (c >= 10 && c <= 13) e = pre[c-10];
         checks++; if (ack0 !== ea) begin errors++; $display("FAIL b2b_ack c%0d got %b want %b", c, ack0, ea); end
         checks++; if (do0 !== e) begin errors++; $display("FAIL b2b_do c%0d got %h want %h", c, do0, e); end
         if (c == 10) stb0 = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_burst;
      burst(0, 1'b1, 26'hC0, old, 4'hF, 8, -1);
      burst(0, 1'b1, 26'hC0, nw, 4'hF, 8, 4);
      checks++; if (ack_log[4] !== 1'b0) begin errors++; $display("FAIL rstw_ack got %b want 0", ack_log[4]); end
      burst(0, 1'b0, 26'hC0, nw, 4'hF, 8, -1);
      checks++; if (do_log[3] !== nw[0]) begin errors++; $display("FAIL rstw_beat0 got %h want %h", do_log[3], nw[0]); end
      for (int b = 1; b < 4; b++) begin
         checks++; if (do_log[3+b] !== old[b]) begin errors++; $display("FAIL rstw_beat%0d got %h want %h", b, do_log[3+b], old[b]); end
      end
      burst(0, 1'b0, 26'hC0, nw, 4'hF, 8, 4);
      checks++; if (do_log[3] !== nw[0]) begin errors++; $display("FAIL rstr_pre got %h want %h", do_log[3], nw[0]); end
      for (int c = 4; c < 8; c++) begin
         checks++; if (do_log[c] !== 32'h0 || ack_log[c] !== 1'b0) begin errors++; $display("FAIL rstr_c%0d got do=%h ack=%b want 0/0", c, do_log[c], ack_log[c]); end
      end
   endtask

   task automatic test_wrap;
      logic [31:0] e;
      burst(1, 1'b1, 26'hFFF0, wrp, 4'hF, 6, -1);
      burst(1, 1'b0, 26'h3FFF5, wrp, 4'hF, 6, -1);
      for (int c = 0; c < 6; c++) begin
         e = (c >= 1 && c <= 4) ? wrp[c-1] : 32'h0;
         checks++; if (ack_log[c] !== (c == 1)) begin errors++; $display("FAIL wrap_ack c%0d got %b want %b", c, ack_log[c], c == 1); end
         checks++; if (do_log[c] !== e) begin errors++; $display("FAIL wrap_do c%0d got %h want %h", c, do_log[c], e); end
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write_read;
      test_sel;
      test_back_to_back;
      test_reset_mid_burst;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fml_bram.md
FML_BRAM -- requirements
Module: fml_bram

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 26, FML byte-address width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of RAM depth in 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 3, cycles from stb acceptance to ack; legal range 1..15.
REQ-004 SHALL have port sys_clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fml_adr, input, ADR_WIDTH, burst byte address.
REQ-007 SHALL have port fml_stb, input, 1, request strobe, held by initiator until ack.
REQ-008 SHALL have port fml_we, input, 1, 1 = write burst, 0 = read burst.
REQ-009 SHALL have port fml_sel, input, 4, byte enables per write beat.
REQ-010 SHALL have port fml_di, input, 32, write data from initiator.
REQ-011 SHALL have port fml_ack, output, 1, one-cycle acknowledge marking beat 0.
REQ-012 SHALL have port fml_do, output, 32, read data to initiator.

Function
REQ-013 SHALL implement states IDLE, WAIT, BURST.
REQ-014 IDLE: fml_stb=1 accepts request; latch fml_adr, fml_we; load latency counter with LATENCY-1; go WAIT.
REQ-015 WAIT: decrement counter each cycle; at 0 go BURST with beat counter 0.
REQ-016 fml_ack SHALL be 1 exactly in the first BURST cycle, LATENCY cycles after acceptance cycle.
REQ-017 BURST SHALL last exactly 4 cycles (beats 0..3), then return IDLE.
REQ-018 Word index SHALL be {fml_adr[DEPTH_LOG2+1:4], beat[1:0]}; fml_adr[3:0] and bits above DEPTH_LOG2+1 ignored (wrap modulo depth).
REQ-019 Read: fml_do SHALL carry word for beat n during BURST cycle n; RAM fetch for beat 0 issued in last WAIT cycle.
REQ-020 fml_do SHALL be 0 in IDLE and WAIT.
REQ-021 Write: fml_di SHALL be sampled during BURST cycle n and written to word for beat n.
REQ-022 fml_stb/fml_adr/fml_we changes during WAIT or BURST SHALL be ignored.
REQ-023 New request SHALL be acceptable in the IDLE cycle immediately after beat 3; fml_stb still high then starts a new burst.
REQ-024 Read of a word written by a prior burst SHALL return the written value (no stale data).

Reset
REQ-025 Assertion SHALL immediately force IDLE, fml_ack=0, fml_do=0, counters 0, mid-burst included; incomplete write beats SHALL not be written.
REQ-026 RAM contents SHALL not be reset; deassertion SHALL take effect on next sys_clk rising edge.

Configuration
REQ-027 Macro FML_BRAM_SEL_EN defined: write beat updates only bytes with fml_sel[i]=1 (bit i = fml_di[8i+7:8i]).
REQ-028 FML_BRAM_SEL_EN undefined: fml_sel ignored, every write beat writes all 4 bytes.

Structure
REQ-029 Package fml_pkg SHALL hold FML_BURST_LEN=4, FML_DW=32, state encoding constants.
REQ-030 Single-port synchronous RAM with byte-enable SHALL be sub-module fml_bram_ram; FSM/counters stay in fml_bram.

Verification
REQ-031 Read, LATENCY=3: stb at cycle 0, adr 0x0, RAM preloaded words 0..3 = 0x11111111..0x44444444 -> ack at cycle 3 only, fml_do 0x11111111..0x44444444 cycles 3..6, 0 at cycle 7.
REQ-032 Write then read adr 0x40, di 0xDEADBEEF,0xCAFEF00D,0x01234567,0x89ABCDEF -> read burst returns same four words in order.
REQ-033 SEL_EN defined: write 0xFFFFFFFF fill, then write beat 0 di 0x00000000 sel 4'b0101 -> readback beat 0 = 0xFF00FF00; undefined -> 0x00000000.
REQ-034 stb held high continuously (bench-style ack pacing) -> back-to-back bursts, ack every LATENCY+4 cycles, no beat overlap.
REQ-035 sys_rst_n low during beat 1 of write -> fml_ack/fml_do 0 immediately, state IDLE; beats 1..3 not written, beat 0 retained.
REQ-036 LATENCY=1, adr 0xFFF0 with DEPTH_LOG2=10 -> ack one cycle after acceptance, words 1020..1023 accessed (wrap), data correct.
